// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front-end that shares one 8-bit combinational ALU between two
// requesters, registering the winner's operands and returning the settled result with DONE.
module alu_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ0,
    input  logic [7:0] OPA0,
    input  logic [7:0] OPB0,
    input  logic [2:0] OP0,
    output logic       GNT0,
    output logic       DONE0,
    input  logic       REQ1,
    input  logic [7:0] OPA1,
    input  logic [7:0] OPB1,
    input  logic [2:0] OP1,
    output logic       GNT1,
    output logic       DONE1,
    output logic [7:0] ALU_DATA1,
    output logic [7:0] ALU_DATA2,
    output logic [2:0] ALU_SELECT,
    input  logic [7:0] ALU_RESULT,
    output logic [7:0] RESULT_OUT,
    output logic       BUSY
);
    localparam int CW = $clog2(WAIT_CYCLES + 1);
    typedef enum logic {IDLE, EXEC} state_t;
    state_t state;
    logic last;
    logic win;
    logic [CW-1:0] cnt;
    // requester 1 wins when it is alone, or on a tie when requester 0 was served last
    always_comb win = REQ1 & (~REQ0 | ~last);
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state      <= IDLE;
            last       <= 1'b1;
            cnt        <= '0;
            GNT0       <= 1'b0;
            GNT1       <= 1'b0;
            DONE0      <= 1'b0;
            DONE1      <= 1'b0;
            BUSY       <= 1'b0;
            ALU_DATA1  <= '0;
            ALU_DATA2  <= '0;
            ALU_SELECT <= '0;
            RESULT_OUT <= '0;
        end else begin
            GNT0  <= 1'b0;
            GNT1  <= 1'b0;
            DONE0 <= 1'b0;
            DONE1 <= 1'b0;
            if (state == IDLE) begin
                if (REQ0 | REQ1) begin
                    ALU_DATA1  <= win ? OPA1 : OPA0;
                    ALU_DATA2  <= win ? OPB1 : OPB0;
                    ALU_SELECT <= win ? OP1 : OP0;
                    GNT0       <= ~win;
                    GNT1       <= win;
                    last       <= win;
                    BUSY       <= 1'b1;
                    cnt        <= CW'(WAIT_CYCLES);
                    state      <= EXEC;
                end
            end else if (cnt == CW'(1)) begin
                RESULT_OUT <= ALU_RESULT;
                DONE0      <= ~last;
                DONE1      <= last;
                BUSY       <= 1'b0;
                state      <= IDLE;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Clocked front-end that shares the single 8-bit ALU between two requesters (e.g. the CPU instruction path and a secondary datapath unit).
- Arbitrates requests round-robin.
- Registers the winner's operands and opcode onto the ALU inputs.
- Waits a fixed number of cycles for the ALU's combinational delay to settle.
- Captures the result and returns it with a one-cycle completion pulse to the winning requester.

Parameters:
WAIT_CYCLES, 1, clock cycles between driving ALU inputs and sampling ALU_RESULT; legal range is 1 or more (0 is illegal).

Ports:
CLK  input  1  system clock, all state on rising edge
RESET  input  1  synchronous, active-low reset
REQ0  input  1  requester 0 request
OPA0  input  8  requester 0 operand, drives ALU DATA1
OPB0  input  8  requester 0 operand, drives ALU DATA2
OP0  input  3  requester 0 ALU select code
GNT0  output  1  one-cycle pulse: requester 0 accepted, operands sampled
DONE0  output  1  one-cycle pulse: requester 0 result valid on RESULT_OUT
REQ1, OPA1, OPB1, OP1, GNT1, DONE1  same as requester 0, for requester 1
ALU_DATA1  output  8  registered operand to ALU
ALU_DATA2  output  8  registered operand to ALU
ALU_SELECT  output  3  registered select to ALU
ALU_RESULT  input  8  ALU combinational result
RESULT_OUT  output  8  captured result, holds until next completion
BUSY  output  1  high while an operation is in flight

Behaviour:
- All outputs are registered. Reset is applied when RESET=0 at a rising edge.
- Reset state:
  - all outputs 0, state IDLE, round-robin pointer LAST=1 (requester 0 wins the first tie).
  - Reset aborts any in-flight operation; no DONE is issued for it.
- States: IDLE, EXEC.
- IDLE, at edge k:
  - If neither REQ is high: stay in IDLE.
  - If only one REQ is high: grant that requester.
  - If both are high: grant the requester not equal to LAST.
  - On a grant: ALU_DATA1/ALU_DATA2/ALU_SELECT <= OPAx/OPBx/OPx; GNTx<=1; LAST<=x; BUSY<=1; counter<=WAIT_CYCLES; go to EXEC.
- EXEC:
  - GNTx cleared at edge k+1.
  - Counter decrements each edge.
  - At edge k+WAIT_CYCLES: RESULT_OUT<=ALU_RESULT; DONEx<=1 for exactly one cycle; BUSY<=0; go to IDLE.
- Latency and throughput:
  - Grant to DONE latency is WAIT_CYCLES edges.
  - Earliest next acceptance is edge k+WAIT_CYCLES+1.
  - Throughput is one operation per WAIT_CYCLES+1 cycles.
- Handshake:
  - A requester holds REQ and operands stable until it sees GNT, then drops REQ.
  - REQ still high at a later IDLE edge is a new request.
  - REQ changes during EXEC are ignored.
- ALU_DATA1/ALU_DATA2/ALU_SELECT hold their last values after completion and change only on a grant.
- SELECT encoding is passed through unchanged: 000 forward DATA2, 001 add, 010 and, 011 or, others forward DATA2 (ALU default).
- Add is modulo 256; no carry is reported.
- Only one GNT and one DONE may be high in any cycle.
- GNT and DONE never overlap for different requesters in the same cycle.
- RESULT_OUT is not cleared between operations.

Test Plan:
1. Reset: RESET=0 for 2 cycles with REQ0=1, REQ1=1 -> GNT0/GNT1/DONE0/DONE1/BUSY=0, ALU_*=0, RESULT_OUT=0x00 throughout reset.
2. Single add: REQ0, OPA0=0x01, OPB0=0x03, OP0=001 -> GNT0 one cycle after edge k; DONE0 one cycle after edge k+WAIT_CYCLES; RESULT_OUT=0x04; BUSY high exactly WAIT_CYCLES cycles.
3. Simultaneous requests after reset:
   - Stimulus: REQ0 with OPA0=0xD5, OPB0=0xEA, OP0=010; REQ1 with OPA1=0x01, OPB1=0x02, OP1=011.
   - Response: requester 0 served first, RESULT_OUT=0xC0 with DONE0.
   - Then requester 1 is granted at the next IDLE edge, RESULT_OUT=0x03 with DONE1, WAIT_CYCLES+1 cycles after DONE0.
4. Fairness: REQ0 and REQ1 held high continuously for 4 operations (requesters re-raise REQ after GNT) -> grant order 0,1,0,1; no GNT during BUSY.
5. Reset mid-EXEC: grant REQ1 add 0xFF+0x02, assert RESET=0 before completion -> no DONE1, BUSY=0, RESULT_OUT=0x00. After release, a simultaneous request pair grants requester 0 first.
6. Forward and default: OP0=000, OPB0=0x7E -> RESULT_OUT=0x7E; OP1=111, OPA1=0x81, OPB1=0x4E -> RESULT_OUT=0x4E; add 0xFF+0x02 -> RESULT_OUT=0x01 (wrap-around).
